// File: rtl/apb_bridge_mslv_if.sv
// Bus bundle for apb_bridge_mslv: system-side request/response port plus the
// APB master signals toward the slave cluster.
interface apb_bridge_mslv_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 4
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  // Bridge view: system-bus slave, APB master.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  // Environment view: system requester and APB slave cluster.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_bridge_mslv.sv
// Single-outstanding valid/ready to APB master bridge with address-based slave
// decode, wait states, slave error reporting and a wait-state timeout.
module apb_bridge_mslv #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  apb_bridge_mslv_if.slave bus
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SEL_W:0]     NUM_SLV_V = (SEL_W + 1)'(NUM_SLV);
  localparam logic [CNT_W-1:0]   TO_VAL    = CNT_W'(TIMEOUT);
  localparam logic [NUM_SLV-1:0] SEL_ONE   = NUM_SLV'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [SEL_W-1:0]    idx_q, idx_d;

  logic                req_ready;
  logic [SEL_W-1:0]    req_idx;
  logic [DATA_W-1:0]   prdata_arr [NUM_SLV];

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_rd
    assign prdata_arr[i] = bus.prdata[i*DATA_W +: DATA_W];
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign req_idx   = bus.req_addr[ADDR_W-1 -: SEL_W];

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    wait_cnt_d  = wait_cnt_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wdata;
          pwrite_d = bus.req_write;
          idx_d    = req_idx;
          if ({1'b0, req_idx} < NUM_SLV_V) begin
            state_d    = SETUP;
            psel_d     = SEL_ONE << req_idx;
            penable_d  = 1'b0;
            wait_cnt_d = '0;
          end else begin
            // Unmapped slave: answer with an error and never touch the APB.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (bus.pready[idx_q]) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr[idx_q];
          rsp_rdata_d = (!pwrite_q && !bus.pslverr[idx_q]) ? prdata_arr[idx_q] : '0;
        end else if ((TIMEOUT > 0) && (wait_cnt_q == TO_VAL)) begin
          // pready has a priority over the timeout in the last allowed cycle.
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_cnt_q  <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_cnt_q  <= wait_cnt_d;
      idx_q       <= idx_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_bridge_mslv.sv
// Bench for apb_bridge_mslv: a 4-slave and a 3-slave instance share the request
// and slave-side stimulus; each transaction targets one of them.
module tb_apb_bridge_mslv;
  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid4 = 1'b0;
  logic        req_valid3 = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [31:0] prdata = '0;
  logic [3:0]  pready = '0;
  logic [3:0]  pslverr = '0;
  bit          sel3 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_bridge_mslv_if #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(4)) if4 ();
  apb_bridge_mslv_if #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3)) if3 ();

  apb_bridge_mslv #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(4), .TIMEOUT(T))
    u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  apb_bridge_mslv #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(T))
    u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  assign if4.req_valid = req_valid4;
  assign if4.req_write = req_write;
  assign if4.req_addr  = req_addr;
  assign if4.req_wdata = req_wdata;
  assign if4.prdata    = prdata;
  assign if4.pready    = pready;
  assign if4.pslverr   = pslverr;

  assign if3.req_valid = req_valid3;
  assign if3.req_write = req_write;
  assign if3.req_addr  = req_addr;
  assign if3.req_wdata = req_wdata;
  assign if3.prdata    = prdata[23:0];
  assign if3.pready    = pready[2:0];
  assign if3.pslverr   = pslverr[2:0];

  logic       o_req_ready, o_rsp_valid, o_rsp_err, o_penable, o_pwrite;
  logic [7:0] o_rsp_rdata, o_paddr, o_pwdata;
  logic [3:0] o_psel;

  assign o_req_ready = sel3 ? if3.req_ready : if4.req_ready;
  assign o_rsp_valid = sel3 ? if3.rsp_valid : if4.rsp_valid;
  assign o_rsp_err   = sel3 ? if3.rsp_err   : if4.rsp_err;
  assign o_rsp_rdata = sel3 ? if3.rsp_rdata : if4.rsp_rdata;
  assign o_penable   = sel3 ? if3.penable   : if4.penable;
  assign o_pwrite    = sel3 ? if3.pwrite    : if4.pwrite;
  assign o_paddr     = sel3 ? if3.paddr     : if4.paddr;
  assign o_pwdata    = sel3 ? if3.pwdata    : if4.pwdata;
  assign o_psel      = sel3 ? {1'b0, if3.psel} : if4.psel;

  typedef struct {
    bit         s3;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    bit         serr;
    logic [7:0] rd;
    int         lat;
    bit         err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: the response follows from the slave decode, how long the slave
  // stalls and whether the stall exceeds the timeout allowance.
  function automatic void model(input bit s3, input bit wr, input logic [7:0] addr,
                                input int waits, input bit serr, input logic [7:0] rd,
                                output int lat, output bit err, output logic [7:0] rdata);
    int nslv = s3 ? 3 : 4;
    int slv  = int'(addr) / 64;
    if (slv >= nslv) begin
      lat = 1; err = 1'b1; rdata = 8'h00;
    end else if (waits > T) begin
      lat = 3 + T; err = 1'b1; rdata = 8'h00;
    end else begin
      lat = 3 + waits; err = serr; rdata = (!wr && !serr) ? rd : 8'h00;
    end
  endfunction

  // The target slave raises pready after 'waits' ACCESS cycles; other slaves
  // toggle pready/pslverr/prdata randomly throughout.
  task automatic run_txn(input string nm, input bit s3, input bit wr,
                         input logic [7:0] addr, input logic [7:0] wdata,
                         input int waits, input bit serr, input logic [7:0] rd,
                         input int exp_lat, input bit exp_err, input logic [7:0] exp_rd);
    int          slv;
    bit          got;
    logic [31:0] tmp;
    logic [3:0]  nz;
    logic [31:0] onehot;
    slv    = int'(addr[7:6]);
    onehot = 32'd1 << slv;
    got    = 1'b0;
    @(negedge clk);
    sel3 = s3;
    #1;
    chk({nm, " req_ready idle"}, 32'(o_req_ready), 32'd1);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tmp = $urandom; tmp[slv*8 +: 8] = rd; prdata = tmp;
    nz = 4'($urandom); nz[slv] = 1'b0;  pready  = nz;
    nz = 4'($urandom); nz[slv] = serr;  pslverr = nz;
    if (s3) req_valid3 = 1'b1; else req_valid4 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      req_valid3 = 1'b0;
      req_valid4 = 1'b0;
      if (k == 1 && exp_lat > 1) begin
        chk({nm, " setup psel"},    32'(o_psel),    onehot);
        chk({nm, " setup penable"}, 32'(o_penable), 32'd0);
        chk({nm, " setup paddr"},   32'(o_paddr),   32'(addr));
        chk({nm, " setup pwdata"},  32'(o_pwdata),  32'(wdata));
        chk({nm, " setup pwrite"},  32'(o_pwrite),  32'(wr));
      end
      if (k == 2 && exp_lat > 2) begin
        chk({nm, " access psel"},    32'(o_psel),    onehot);
        chk({nm, " access penable"}, 32'(o_penable), 32'd1);
        chk({nm, " access paddr"},   32'(o_paddr),   32'(addr));
      end
      if (o_rsp_valid) begin
        got = 1'b1;
        chk({nm, " latency"},     32'(k),           32'(exp_lat));
        chk({nm, " rsp_err"},     32'(o_rsp_err),   32'(exp_err));
        chk({nm, " rsp_rdata"},   32'(o_rsp_rdata), 32'(exp_rd));
        chk({nm, " resp psel"},   32'(o_psel),      32'd0);
        chk({nm, " resp penable"},32'(o_penable),   32'd0);
        chk({nm, " resp ready"},  32'(o_req_ready), 32'd0);
      end else begin
        tmp = $urandom; tmp[slv*8 +: 8] = rd; prdata = tmp;
        nz = 4'($urandom); nz[slv] = (k >= 2 + waits); pready  = nz;
        nz = 4'($urandom); nz[slv] = serr;             pslverr = nz;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s no rsp_valid: got none in 40 cycles, want one at cycle %0d", nm, exp_lat);
    end else begin
      @(negedge clk);
      chk({nm, " rsp_valid single"}, 32'(o_rsp_valid), 32'd0);
      chk({nm, " idle ready"},       32'(o_req_ready), 32'd1);
    end
    pready  = '0;
    pslverr = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt;
    int         lat;
    bit         err;
    logic [7:0] erd;
    bit         s3, wr, serr;
    logic [7:0] addr, wd, rd;
    int         waits;

    vecs[0] = '{1'b0, 1'b1, 8'h45, 8'hA5,  0, 1'b0, 8'h11,  3, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'hC3, 8'h00,  3, 1'b0, 8'h5C,  6, 1'b0, 8'h5C};
    vecs[2] = '{1'b0, 1'b0, 8'h80, 8'h00,  0, 1'b1, 8'h77,  3, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 8'h05, 8'h00, 20, 1'b0, 8'h66, 18, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'hC0, 8'h00,  0, 1'b0, 8'h99,  1, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'hC7, 8'h3E, 15, 1'b0, 8'h00, 18, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 8'h12, 8'h00,  1, 1'b0, 8'h3C,  4, 1'b0, 8'h3C};
    vecs[7] = '{1'b0, 1'b1, 8'h9F, 8'hD2,  2, 1'b1, 8'h00,  5, 1'b1, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 8'h8A, 8'h00,  0, 1'b0, 8'hE1,  3, 1'b0, 8'hE1};
    vecs[9] = '{1'b0, 1'b0, 8'h40, 8'h00, 14, 1'b1, 8'hAB, 17, 1'b1, 8'h00};

    // Reset state
    #2;
    chk("reset req_ready",  32'(if4.req_ready), 32'd0);
    chk("reset rsp_valid",  32'(if4.rsp_valid), 32'd0);
    chk("reset psel",       32'(if4.psel),      32'd0);
    chk("reset penable",    32'(if4.penable),   32'd0);
    chk("reset paddr",      32'(if4.paddr),     32'd0);
    chk("reset rsp_rdata",  32'(if4.rsp_rdata), 32'd0);
    chk("reset3 req_ready", 32'(if3.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].s3, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].waits, vecs[i].serr, vecs[i].rd, vecs[i].lat, vecs[i].err, vecs[i].exp_rd);
    end

    for (int i = 0; i < 40; i++) begin
      s3    = 1'($urandom);
      wr    = 1'($urandom);
      addr  = 8'($urandom);
      wd    = 8'($urandom);
      rd    = 8'($urandom);
      serr  = ($urandom_range(0, 3) == 0);
      waits = $urandom_range(0, 18);
      model(s3, wr, addr, waits, serr, rd, lat, err, erd);
      run_txn($sformatf("rnd%0d", i), s3, wr, addr, wd, waits, serr, rd, lat, err, erd);
    end

    // Reset during ACCESS aborts the transfer without a response.
    @(negedge clk);
    sel3 = 1'b0;
    req_write = 1'b0; req_addr = 8'h40; req_wdata = 8'h00;
    pready = '0; pslverr = '0;
    req_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
    @(negedge clk);
    chk("abort access penable", 32'(o_penable), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort psel",      32'(o_psel),      32'd0);
    chk("abort penable",   32'(o_penable),   32'd0);
    chk("abort rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("abort paddr",     32'(o_paddr),     32'd0);
    chk("abort pwrite",    32'(o_pwrite),    32'd0);
    chk("abort req_ready", 32'(o_req_ready), 32'd0);
    pready = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_rsp_valid) cnt++;
    end
    chk("abort no response", 32'(cnt), 32'd0);
    pready = '0;
    run_txn("post-reset write", 1'b0, 1'b1, 8'h0A, 8'h5A, 0, 1'b0, 8'h00, 3, 1'b0, 8'h00);
    run_txn("post-reset read",  1'b0, 1'b0, 8'h0A, 8'h00, 0, 1'b0, 8'hC4, 3, 1'b0, 8'hC4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
